// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU interface.
// Holds the ALU op code enum, the RV32I opcode and funct7 constants that the
// issue decoder matches on, and the packed entry that travels from the issue
// stage to execute. The execute-stage ALU imports alu_op_t from here.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_PASS = 4'd15
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_t           aluOp;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [4:0]        rd;
    logic              we;
    logic              illegal;
  } issue_entry_t;

  // Value every entry register holds coming out of reset.
  localparam issue_entry_t RESET_ENTRY = '{
    aluOp:   ALU_PASS,
    a:       '0,
    b:       '0,
    rd:      5'd0,
    we:      1'b0,
    illegal: 1'b0
  };

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decoder: RV32I instruction word, PC and register-file operands
// in, one fully formed issue entry out.
// Ports:
//   instr_i    - RV32I instruction word
//   pc_i       - instruction PC
//   rs1Data_i  - rs1 register value
//   rs2Data_i  - rs2 register value
//   entry_o    - op code, operands, rd, write enable, illegal flag
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  rs1Data_i,
  input  logic [XLEN-1:0]  rs2Data_i,
  output issue_entry_t     entry_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd     = instr_i[11:7];

  // The rs1 index field is consumed by the register file, not by this decoder.
  logic unusedRs1Idx;
  assign unusedRs1Idx = ^instr_i[19:15];

  logic            legal;
  alu_op_t         op;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;

  // Classify the instruction and pick operands; anything not explicitly
  // recognised stays illegal, which covers SLT/SLTU/SLTI/SLTIU and bad funct7.
  always_comb begin
    legal = 1'b0;
    op    = ALU_PASS;
    opA   = '0;
    opB   = '0;
    case (opcode)
      OPC_OP: begin
        opA = rs1Data_i;
        opB = rs2Data_i;
        if (funct7 == FUNCT7_BASE) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: legal = 1'b0;
          endcase
        end else if (funct7 == FUNCT7_ALT) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  op = ALU_SUB;
            3'b101:  op = ALU_SRA;
            default: legal = 1'b0;
          endcase
        end
      end
      OPC_OP_IMM: begin
        opA = rs1Data_i;
        opB = {{20{instr_i[31]}}, instr_i[31:20]};
        case (funct3)
          3'b000: begin op = ALU_ADD; legal = 1'b1; end
          3'b100: begin op = ALU_XOR; legal = 1'b1; end
          3'b110: begin op = ALU_OR;  legal = 1'b1; end
          3'b111: begin op = ALU_AND; legal = 1'b1; end
          3'b001: begin
            op    = ALU_SLL;
            opB   = {27'd0, instr_i[24:20]};
            legal = (funct7 == FUNCT7_BASE);
          end
          3'b101: begin
            op    = (funct7 == FUNCT7_ALT) ? ALU_SRA : ALU_SRL;
            opB   = {27'd0, instr_i[24:20]};
            legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal = 1'b1;
        op    = ALU_PASS;
        opA   = '0;
        opB   = {instr_i[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        op    = ALU_ADD;
        opA   = pc_i;
        opB   = {instr_i[31:12], 12'd0};
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal instructions are squashed to a harmless PASS of zero with no write.
  always_comb begin
    entry_o.aluOp   = legal ? op : ALU_PASS;
    entry_o.a       = legal ? opA : '0;
    entry_o.b       = legal ? opB : '0;
    entry_o.rd      = rd;
    entry_o.we      = legal && (rd != 5'd0);
    entry_o.illegal = !legal;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction from ID and registers it into the
// ID/EX boundary behind a valid/ready handshake on both sides. A main entry
// feeds execute; a skid entry catches the one instruction that may arrive
// while main is stalled, so id_ready can be a plain register.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   flush          - drops every buffered entry
//   id_valid/id_ready, id_instr, id_pc, id_rs1_data, id_rs2_data - upstream
//   ex_valid/ex_ready, ex_alu_op, ex_a, ex_b, ex_rd, ex_we, ex_illegal - execute
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [31:0]      id_instr,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [3:0]       ex_alu_op,
  output logic [XLEN-1:0]  ex_a,
  output logic [XLEN-1:0]  ex_b,
  output logic [4:0]       ex_rd,
  output logic             ex_we,
  output logic             ex_illegal
);

  issue_entry_t decoded;

  alu_issue_decode uDecode (
    .instr_i   (id_instr),
    .pc_i      (id_pc),
    .rs1Data_i (id_rs1_data),
    .rs2Data_i (id_rs2_data),
    .entry_o   (decoded)
  );

  logic         mainValid_q, mainValid_d;
  logic         skidValid_q, skidValid_d;
  logic         idReady_q,   idReady_d;
  issue_entry_t mainEntry_q, mainEntry_d;
  issue_entry_t skidEntry_q, skidEntry_d;

  logic accept;
  logic drain;

  assign accept = id_valid && idReady_q;
  assign drain  = mainValid_q && ex_ready;

  // Main refills from skid first so order is kept; only with skid empty can a
  // new instruction go straight to main, which gives full throughput. When main
  // is held by execute a new arrival parks in skid. Flush beats acceptance.
  always_comb begin
    mainValid_d = mainValid_q;
    skidValid_d = skidValid_q;
    mainEntry_d = mainEntry_q;
    skidEntry_d = skidEntry_q;
    if (flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (!mainValid_q || drain) begin
      if (skidValid_q) begin
        mainValid_d = 1'b1;
        mainEntry_d = skidEntry_q;
        skidValid_d = 1'b0;
      end else if (accept) begin
        mainValid_d = 1'b1;
        mainEntry_d = decoded;
      end else begin
        mainValid_d = 1'b0;
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skidEntry_d = decoded;
    end
    idReady_d = !skidValid_d;
  end

  // State registers; reset also loads the visible data fields with defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      idReady_q   <= 1'b1;
      mainEntry_q <= RESET_ENTRY;
      skidEntry_q <= RESET_ENTRY;
    end else begin
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
      idReady_q   <= idReady_d;
      mainEntry_q <= mainEntry_d;
      skidEntry_q <= skidEntry_d;
    end
  end

  assign id_ready   = idReady_q;
  assign ex_valid   = mainValid_q;
  assign ex_alu_op  = mainEntry_q.aluOp;
  assign ex_a       = mainEntry_q.a;
  assign ex_b       = mainEntry_q.b;
  assign ex_rd      = mainEntry_q.rd;
  assign ex_we      = mainEntry_q.we;
  assign ex_illegal = mainEntry_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue: decode vectors, back-pressure through the
// skid entry, flush and mid-stall reset, with hand-computed expectations.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        ex_illegal;

  int checkCount = 0;
  int failCount  = 0;

  alu_issue #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_alu_op   (ex_alu_op),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_rd       (ex_rd),
    .ex_we       (ex_we),
    .ex_illegal  (ex_illegal)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a wedged run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives all upstream inputs on the falling edge, away from sampling.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [31:0] rs1,
                               input logic [31:0] rs2);
    @(negedge clk);
    id_valid    = valid;
    id_instr    = instr;
    id_pc       = pc;
    id_rs1_data = rs1;
    id_rs2_data = rs2;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkEntry(input string tag, input int op, input logic [31:0] a,
                            input logic [31:0] b, input int rd, input int we,
                            input int ill);
    checkOutput({tag, ".op"},  {28'd0, ex_alu_op}, op);
    checkOutput({tag, ".a"},   ex_a, a);
    checkOutput({tag, ".b"},   ex_b, b);
    checkOutput({tag, ".rd"},  {27'd0, ex_rd}, rd);
    checkOutput({tag, ".we"},  {31'd0, ex_we}, we);
    checkOutput({tag, ".ill"}, {31'd0, ex_illegal}, ill);
  endtask

  // One instruction through with execute ready; checked one edge after accept.
  task automatic issueOne(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input int op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int rd, input int we, input int ill);
    applyStimulus(1'b1, instr, pc, rs1, rs2);
    stepEdge();
    checkOutput({tag, ".valid"}, {31'd0, ex_valid}, 1);
    checkEntry(tag, op, a, b, rd, we, ill);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    stepEdge();
    checkOutput({tag, ".drained"}, {31'd0, ex_valid}, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    id_valid = 1'b0; id_instr = '0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0;
    stepEdge();
    stepEdge();
    checkOutput("reset.exValid", {31'd0, ex_valid}, 0);
    checkOutput("reset.idReady", {31'd0, id_ready}, 1);
    checkEntry("reset", 15, 32'd0, 32'd0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Decode vectors.
    issueOne("add",   32'h002081B3, 32'h0,   32'd5, 32'd7,  0, 32'd5, 32'd7, 3, 1, 0);
    issueOne("sub",   32'h402081B3, 32'h0,   32'd9, 32'd4,  1, 32'd9, 32'd4, 3, 1, 0);
    issueOne("srai",  32'h40435293, 32'h0,   32'h80000000, 32'd0,
             7, 32'h80000000, 32'd4, 5, 1, 0);
    issueOne("lui",   32'h123450B7, 32'h40,  32'd3, 32'd3, 15, 32'd0, 32'h12345000, 1, 1, 0);
    issueOne("auipc", 32'h00001117, 32'h100, 32'd3, 32'd3,  0, 32'h100, 32'h1000, 2, 1, 0);
    issueOne("slt",   32'h0020A1B3, 32'h0,   32'd1, 32'd2, 15, 32'd0, 32'd0, 3, 0, 1);
    issueOne("addiX0",32'h00500013, 32'h0,   32'd8, 32'd0,  0, 32'd8, 32'd5, 0, 0, 0);
    issueOne("addiNeg",32'hFFF08093, 32'h0,  32'd8, 32'd0,  0, 32'd8, 32'hFFFFFFFF, 1, 1, 0);
    issueOne("badF7", 32'h202081B3, 32'h0,   32'd1, 32'd2, 15, 32'd0, 32'd0, 3, 0, 1);

    // Back-pressure: three addi x1..x3 with execute stalled.
    @(negedge clk); ex_ready = 1'b0;
    applyStimulus(1'b1, 32'h00100093, 32'h0, 32'd0, 32'd0);
    stepEdge();
    checkOutput("bp.e1.valid", {31'd0, ex_valid}, 1);
    checkOutput("bp.e1.idReady", {31'd0, id_ready}, 1);
    applyStimulus(1'b1, 32'h00200113, 32'h0, 32'd0, 32'd0);
    stepEdge();
    checkOutput("bp.e2.idReady", {31'd0, id_ready}, 0);
    checkOutput("bp.e2.rd", {27'd0, ex_rd}, 1);
    applyStimulus(1'b1, 32'h00300193, 32'h0, 32'd0, 32'd0);
    stepEdge();
    checkOutput("bp.e3.idReady", {31'd0, id_ready}, 0);
    checkOutput("bp.e3.rd", {27'd0, ex_rd}, 1);
    checkOutput("bp.e3.b", ex_b, 32'd1);
    @(negedge clk); ex_ready = 1'b1;
    stepEdge();
    checkOutput("bp.e4.valid", {31'd0, ex_valid}, 1);
    checkOutput("bp.e4.rd", {27'd0, ex_rd}, 2);
    checkOutput("bp.e4.idReady", {31'd0, id_ready}, 1);
    stepEdge();
    checkOutput("bp.e5.valid", {31'd0, ex_valid}, 1);
    checkOutput("bp.e5.rd", {27'd0, ex_rd}, 3);
    checkOutput("bp.e5.b", ex_b, 32'd3);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    stepEdge();
    checkOutput("bp.e6.valid", {31'd0, ex_valid}, 0);

    // Flush with both entries full and a new instruction offered.
    @(negedge clk); ex_ready = 1'b0;
    applyStimulus(1'b1, 32'h00100093, 32'h0, 32'd0, 32'd0);
    stepEdge();
    applyStimulus(1'b1, 32'h00200113, 32'h0, 32'd0, 32'd0);
    stepEdge();
    checkOutput("fl.full.idReady", {31'd0, id_ready}, 0);
    applyStimulus(1'b1, 32'h00300193, 32'h0, 32'd0, 32'd0);
    flush = 1'b1;
    stepEdge();
    checkOutput("fl.exValid", {31'd0, ex_valid}, 0);
    checkOutput("fl.idReady", {31'd0, id_ready}, 1);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    flush = 1'b0; ex_ready = 1'b1;
    stepEdge();
    checkOutput("fl.after1", {31'd0, ex_valid}, 0);
    stepEdge();
    checkOutput("fl.after2", {31'd0, ex_valid}, 0);

    // Transfer on the flush edge itself is discarded.
    @(negedge clk); ex_ready = 1'b0;
    applyStimulus(1'b1, 32'h00100093, 32'h0, 32'd0, 32'd0);
    stepEdge();
    applyStimulus(1'b1, 32'h00200113, 32'h0, 32'd0, 32'd0);
    flush = 1'b1;
    stepEdge();
    checkOutput("flx.exValid", {31'd0, ex_valid}, 0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    flush = 1'b0;
    stepEdge();
    checkOutput("flx.after", {31'd0, ex_valid}, 0);
    checkOutput("flx.idReady", {31'd0, id_ready}, 1);

    // Reset mid-stall, with flush also high so reset must dominate.
    @(negedge clk); ex_ready = 1'b0;
    applyStimulus(1'b1, 32'h00500113, 32'h0, 32'd3, 32'd0);
    stepEdge();
    applyStimulus(1'b1, 32'h00700193, 32'h0, 32'd3, 32'd0);
    stepEdge();
    checkOutput("rs.preValid", {31'd0, ex_valid}, 1);
    applyStimulus(1'b1, 32'h00900213, 32'h0, 32'd3, 32'd0);
    rst = 1'b1; flush = 1'b1;
    stepEdge();
    checkOutput("rs.exValid", {31'd0, ex_valid}, 0);
    checkOutput("rs.idReady", {31'd0, id_ready}, 1);
    checkEntry("rs", 15, 32'd0, 32'd0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    stepEdge();
    checkOutput("rs.after", {31'd0, ex_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
